// File: rtl/cpu_mem_pkg.sv
// Shared types and default widths for the CPU's unified memory port.
package cpu_mem_pkg;

    localparam int unsigned DEF_ADDR_W = 32;
    localparam int unsigned DEF_DATA_W = 32;

    typedef enum logic {ST_IDLE, ST_WAIT_RSP} arb_state_e;

    typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_DM} mem_owner_e;

endpackage

// File: rtl/mem_arb_pick.sv
// Winner select between fetch and data requests.
// Data side wins by default; fetch wins once the data streak has saturated.
module mem_arb_pick #(
    parameter int unsigned MAX_DM_STREAK = 4,
    parameter int unsigned STREAK_W      = 3
) (
    input  logic                if_req,
    input  logic                dm_req,
    input  logic [STREAK_W-1:0] streak,
    output logic                if_win,
    output logic                dm_win
);

    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DM_STREAK);

    logic if_starved;

    always_comb begin
        if_starved = if_req && (streak == STREAK_MAX);
        dm_win     = dm_req && !if_starved;
        if_win     = if_req && !dm_win;
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-ported memory between IF and MEM stages,
// with a single outstanding read whose response is routed back to its owner.
module mem_port_arbiter
    import cpu_mem_pkg::*;
#(
    parameter int unsigned ADDR_W        = DEF_ADDR_W,
    parameter int unsigned DATA_W        = DEF_DATA_W,
    parameter int unsigned MAX_DM_STREAK = 4
) (
    input  logic                clk,
    input  logic                rst_n,

    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_gnt,
    output logic                if_rvalid,
    output logic [DATA_W-1:0]   if_rdata,

    input  logic                dm_req,
    input  logic                dm_we,
    input  logic [ADDR_W-1:0]   dm_addr,
    input  logic [DATA_W-1:0]   dm_wdata,
    input  logic [DATA_W/8-1:0] dm_be,
    output logic                dm_gnt,
    output logic                dm_rvalid,
    output logic [DATA_W-1:0]   dm_rdata,

    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_be,
    input  logic                mem_gnt,
    input  logic                mem_rvalid,
    input  logic [DATA_W-1:0]   mem_rdata,

    output logic                err_rsp
);

    localparam int unsigned BE_W     = DATA_W / 8;
    localparam int unsigned STREAK_W = $clog2(MAX_DM_STREAK + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DM_STREAK);

    arb_state_e            state_q, state_d;
    mem_owner_e            owner_q, owner_d;
    logic [STREAK_W-1:0]   streak_q, streak_d;
    logic                  err_q, err_d;

    logic if_win, dm_win;
    logic issue_ok, rsp_fire, stray_rsp, grant, read_gnt;

    mem_arb_pick #(
        .MAX_DM_STREAK (MAX_DM_STREAK),
        .STREAK_W      (STREAK_W)
    ) u_pick (
        .if_req (if_req),
        .dm_req (dm_req),
        .streak (streak_q),
        .if_win (if_win),
        .dm_win (dm_win)
    );

    // A new request may issue while idle, or in the cycle the pending read returns.
    always_comb begin
        rsp_fire  = (state_q == ST_WAIT_RSP) && mem_rvalid;
        stray_rsp = (state_q == ST_IDLE) && mem_rvalid;
        issue_ok  = (state_q == ST_IDLE) || rsp_fire;
        mem_req   = issue_ok && (if_req || dm_req);
        grant     = mem_req && mem_gnt;
        if_gnt    = grant && if_win;
        dm_gnt    = grant && dm_win;
        read_gnt  = if_gnt || (dm_gnt && !dm_we);
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            owner_q  <= OWN_NONE;
            streak_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            streak_q <= streak_d;
            err_q    <= err_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        streak_d = streak_q;
        err_d    = err_q | stray_rsp;

        if (read_gnt) begin
            state_d = ST_WAIT_RSP;
            owner_d = if_gnt ? OWN_IF : OWN_DM;
        end else if (rsp_fire) begin
            state_d = ST_IDLE;
            owner_d = OWN_NONE;
        end

        if (!if_req || if_gnt) begin
            streak_d = '0;
        end else if (dm_gnt && (streak_q != STREAK_MAX)) begin
            streak_d = streak_q + 1'b1;
        end
    end

    // Outputs
    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_be    = '0;
        if (mem_req && dm_win) begin
            mem_we    = dm_we;
            mem_addr  = dm_addr;
            mem_wdata = dm_wdata;
            mem_be    = dm_be;
        end else if (mem_req && if_win) begin
            mem_addr  = if_addr;
        end

        if_rvalid = rsp_fire && (owner_q == OWN_IF);
        dm_rvalid = rsp_fire && (owner_q == OWN_DM);
        if_rdata  = if_rvalid ? mem_rdata : '0;
        dm_rdata  = dm_rvalid ? mem_rdata : '0;
        err_rsp   = err_q;
    end

    logic unused_be_w;
    assign unused_be_w = ^BE_W;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt, if_rvalid;
    logic [31:0] if_rdata;
    logic        dm_req, dm_we;
    logic [31:0] dm_addr, dm_wdata;
    logic [3:0]  dm_be;
    logic        dm_gnt, dm_rvalid;
    logic [31:0] dm_rdata;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_gnt, mem_rvalid;
    logic [31:0] mem_rdata;
    logic        err_rsp;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W        (32),
        .DATA_W        (32),
        .MAX_DM_STREAK (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_gnt     (if_gnt),
        .if_rvalid  (if_rvalid),
        .if_rdata   (if_rdata),
        .dm_req     (dm_req),
        .dm_we      (dm_we),
        .dm_addr    (dm_addr),
        .dm_wdata   (dm_wdata),
        .dm_be      (dm_be),
        .dm_gnt     (dm_gnt),
        .dm_rvalid  (dm_rvalid),
        .dm_rdata   (dm_rdata),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_be     (mem_be),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .err_rsp    (err_rsp)
    );

    // Inputs change on the falling edge; outputs are checked 1ns later.
    task automatic next_cycle();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        if_req = 0; if_addr = 0;
        dm_req = 0; dm_we = 0; dm_addr = 0; dm_wdata = 0; dm_be = 0;
        mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
    endtask

    task automatic test_reset();
        rst_n = 0;
        idle_inputs();
        #12;
        total++;
        if ({mem_req, if_gnt, dm_gnt, if_rvalid, dm_rvalid, err_rsp} !== 6'b0) begin
            bad++;
            $display("FAIL reset_outputs got=%b want=000000",
                     {mem_req, if_gnt, dm_gnt, if_rvalid, dm_rvalid, err_rsp});
        end
        next_cycle();
        rst_n = 1;
    endtask

    task automatic test_fetch();
        next_cycle();
        if_req = 1; if_addr = 32'h0; mem_gnt = 1;
        #1;
        total++;
        if ({if_gnt, dm_gnt, mem_req, mem_we} !== 4'b1010 || mem_addr !== 32'h0) begin
            bad++;
            $display("FAIL fetch_grant got=%b addr=%h want=1010 addr=0",
                     {if_gnt, dm_gnt, mem_req, mem_we}, mem_addr);
        end
        next_cycle();
        if_req = 0; mem_gnt = 0;
        #1;
        total++;
        if (mem_req !== 1'b0 || if_rvalid !== 1'b0) begin
            bad++;
            $display("FAIL fetch_wait got req=%b rvalid=%b want 0 0", mem_req, if_rvalid);
        end
        next_cycle();
        mem_rvalid = 1; mem_rdata = 32'h00500093;
        #1;
        total++;
        if (if_rvalid !== 1'b1 || if_rdata !== 32'h00500093 ||
            dm_rvalid !== 1'b0 || dm_rdata !== 32'h0) begin
            bad++;
            $display("FAIL fetch_rsp got if=%b/%h dm=%b/%h want 1/00500093 0/0",
                     if_rvalid, if_rdata, dm_rvalid, dm_rdata);
        end
        next_cycle();
        mem_rvalid = 0; mem_rdata = 0;
        #1;
        total++;
        if (if_rvalid !== 1'b0 || err_rsp !== 1'b0) begin
            bad++;
            $display("FAIL fetch_pulse got rvalid=%b err=%b want 0 0", if_rvalid, err_rsp);
        end
    endtask

    task automatic test_both();
        next_cycle();
        if_req = 1; if_addr = 32'h4;
        dm_req = 1; dm_we = 0; dm_addr = 32'h100; mem_gnt = 1;
        #1;
        total++;
        if ({dm_gnt, if_gnt} !== 2'b10 || mem_addr !== 32'h100) begin
            bad++;
            $display("FAIL both_dm_first got dm/if=%b addr=%h want 10 addr=100",
                     {dm_gnt, if_gnt}, mem_addr);
        end
        next_cycle();
        dm_req = 0; mem_rvalid = 1; mem_rdata = 32'h11112222;
        #1;
        total++;
        if (dm_rvalid !== 1'b1 || dm_rdata !== 32'h11112222 || if_rvalid !== 1'b0 ||
            if_gnt !== 1'b1 || mem_addr !== 32'h4) begin
            bad++;
            $display("FAIL both_dm_rsp got dmrv=%b %h ifrv=%b ifgnt=%b addr=%h want 1 11112222 0 1 4",
                     dm_rvalid, dm_rdata, if_rvalid, if_gnt, mem_addr);
        end
        next_cycle();
        if_req = 0; mem_rdata = 32'h33334444;
        #1;
        total++;
        if (if_rvalid !== 1'b1 || if_rdata !== 32'h33334444 || dm_rvalid !== 1'b0) begin
            bad++;
            $display("FAIL both_if_rsp got ifrv=%b %h dmrv=%b want 1 33334444 0",
                     if_rvalid, if_rdata, dm_rvalid);
        end
        next_cycle();
        idle_inputs();
    endtask

    task automatic test_streak();
        // Expected winner per cycle: four DM grants, one IF, then DM again.
        logic [5:0] exp_dm;
        logic [5:0] exp_dm_rv;
        logic [5:0] exp_if_rv;
        exp_dm    = 6'b101111;
        exp_dm_rv = 6'b011110;
        exp_if_rv = 6'b100000;
        for (int k = 0; k < 6; k++) begin
            next_cycle();
            if_req = 1; if_addr = 32'h40;
            dm_req = 1; dm_we = 0; dm_addr = 32'h200 + k; mem_gnt = 1;
            mem_rvalid = (k > 0); mem_rdata = 32'hA000 + k;
            #1;
            total++;
            if (dm_gnt !== exp_dm[k] || if_gnt !== !exp_dm[k] ||
                dm_rvalid !== exp_dm_rv[k] || if_rvalid !== exp_if_rv[k]) begin
                bad++;
                $display("FAIL streak_cycle%0d got dg=%b ig=%b drv=%b irv=%b want %b %b %b %b",
                         k, dm_gnt, if_gnt, dm_rvalid, if_rvalid,
                         exp_dm[k], !exp_dm[k], exp_dm_rv[k], exp_if_rv[k]);
            end
        end
        next_cycle();
        if_req = 0; dm_req = 0; mem_rvalid = 1; mem_rdata = 32'hBEEF;
        #1;
        total++;
        if (dm_rvalid !== 1'b1 || dm_rdata !== 32'hBEEF || mem_req !== 1'b0) begin
            bad++;
            $display("FAIL streak_last got drv=%b %h req=%b want 1 0000beef 0",
                     dm_rvalid, dm_rdata, mem_req);
        end
        next_cycle();
        idle_inputs();
    endtask

    task automatic test_store();
        next_cycle();
        dm_req = 1; dm_we = 1; dm_be = 4'b0011; dm_wdata = 32'hDEADBEEF;
        dm_addr = 32'h300; mem_gnt = 1;
        #1;
        total++;
        if (dm_gnt !== 1'b1 || mem_we !== 1'b1 || mem_be !== 4'b0011 ||
            mem_wdata !== 32'hDEADBEEF || mem_addr !== 32'h300) begin
            bad++;
            $display("FAIL store_issue got g=%b we=%b be=%b wd=%h a=%h want 1 1 0011 deadbeef 300",
                     dm_gnt, mem_we, mem_be, mem_wdata, mem_addr);
        end
        next_cycle();
        dm_req = 0; dm_we = 0; dm_be = 0; dm_wdata = 0;
        if_req = 1; if_addr = 32'h8;
        #1;
        total++;
        if (if_gnt !== 1'b1 || dm_rvalid !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 32'h8) begin
            bad++;
            $display("FAIL store_then_fetch got ig=%b drv=%b we=%b a=%h want 1 0 0 8",
                     if_gnt, dm_rvalid, mem_we, mem_addr);
        end
        next_cycle();
        if_req = 0; mem_rvalid = 1; mem_rdata = 32'h5555;
        #1;
        total++;
        if (if_rvalid !== 1'b1 || if_rdata !== 32'h5555) begin
            bad++;
            $display("FAIL store_fetch_rsp got %b %h want 1 00005555", if_rvalid, if_rdata);
        end
        next_cycle();
        idle_inputs();
    endtask

    task automatic test_stall();
        for (int k = 0; k < 4; k++) begin
            next_cycle();
            if_req = 1; if_addr = 32'hC;
            dm_req = 1; dm_we = 0; dm_addr = 32'h400;
            mem_gnt = (k == 3);
            #1;
            total++;
            if (mem_req !== 1'b1 || if_gnt !== 1'b0 || dm_gnt !== (k == 3)) begin
                bad++;
                $display("FAIL stall_cycle%0d got req=%b ig=%b dg=%b want 1 0 %0d",
                         k, mem_req, if_gnt, dm_gnt, (k == 3));
            end
        end
        next_cycle();
        if_req = 0; dm_req = 0; mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h7777;
        #1;
        total++;
        if (dm_rvalid !== 1'b1 || dm_rdata !== 32'h7777 || if_rvalid !== 1'b0) begin
            bad++;
            $display("FAIL stall_rsp got drv=%b %h irv=%b want 1 00007777 0",
                     dm_rvalid, dm_rdata, if_rvalid);
        end
        next_cycle();
        idle_inputs();
    endtask

    task automatic test_reset_midop();
        next_cycle();
        if_req = 1; if_addr = 32'h10; mem_gnt = 1;
        next_cycle();
        idle_inputs();
        rst_n = 0;
        #1;
        total++;
        if ({mem_req, if_rvalid, dm_rvalid, err_rsp} !== 4'b0) begin
            bad++;
            $display("FAIL midop_reset got=%b want 0000",
                     {mem_req, if_rvalid, dm_rvalid, err_rsp});
        end
        next_cycle();
        rst_n = 1;
        next_cycle();
        mem_rvalid = 1; mem_rdata = 32'h9999;
        #1;
        total++;
        if (if_rvalid !== 1'b0 || dm_rvalid !== 1'b0 || if_rdata !== 32'h0) begin
            bad++;
            $display("FAIL late_rsp_routed got irv=%b drv=%b ird=%h want 0 0 0",
                     if_rvalid, dm_rvalid, if_rdata);
        end
        next_cycle();
        mem_rvalid = 0;
        #1;
        total++;
        if (err_rsp !== 1'b1) begin
            bad++;
            $display("FAIL err_set got=%b want=1", err_rsp);
        end
        for (int k = 0; k < 3; k++) next_cycle();
        #1;
        total++;
        if (err_rsp !== 1'b1) begin
            bad++;
            $display("FAIL err_sticky got=%b want=1", err_rsp);
        end
        rst_n = 0;
        #1;
        total++;
        if (err_rsp !== 1'b0) begin
            bad++;
            $display("FAIL err_clear got=%b want=0", err_rsp);
        end
        next_cycle();
        rst_n = 1;
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_both();
        test_streak();
        test_store();
        test_stall();
        test_reset_midop();
        next_cycle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported unified instruction/data memory between the IF stage (fetch) and the MEM stage (load/store) of the pipelined CPU.
- Arbitrates requests, tracks the one outstanding read, and routes the read response back to its owner.
- Requesters see a grant that doubles as their stall release. The block sits inside CPU_Top, between the pipeline stages and the memory model.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width. BE width is DATA_W/8.
- MAX_DM_STREAK, 4, maximum consecutive data-side grants while a fetch is pending. Must be ≥1.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- if_req  in  1  fetch request, held until if_gnt.
- if_addr  in  ADDR_W  fetch address.
- if_gnt  out  1  fetch accepted this cycle.
- if_rvalid  out  1  fetch data valid, one-cycle pulse.
- if_rdata  out  DATA_W  fetch data.
- dm_req  in  1  data request, held until dm_gnt.
- dm_we  in  1  1 = store, 0 = load.
- dm_addr  in  ADDR_W  data address.
- dm_wdata  in  DATA_W  store data.
- dm_be  in  DATA_W/8  store byte enables.
- dm_gnt  out  1  data request accepted.
- dm_rvalid  out  1  load data valid, one-cycle pulse.
- dm_rdata  out  DATA_W  load data.
- mem_req  out  1  memory request.
- mem_we, mem_addr, mem_wdata, mem_be  out  as above  request fields, muxed from the winner.
- mem_gnt  in  1  memory accepts the request this cycle.
- mem_rvalid  in  1  read data valid.
- mem_rdata  in  DATA_W  read data.
- err_rsp  out  1  sticky flag: mem_rvalid seen with no read outstanding.

Behaviour:
- Reset values: all outputs 0; state = IDLE; streak = 0; owner = NONE.
- FSM states:
  - IDLE: no read outstanding.
  - WAIT_RSP: one read outstanding; owner register = IF or DM.
- Issue is allowed in IDLE, or in WAIT_RSP during the cycle mem_rvalid arrives (back-to-back issue).
- When issue is allowed and any request is pending:
  - mem_req = 1 and mem_* fields are driven combinationally from the winner.
  - mem_we, mem_wdata and mem_be come from dm_* when DM wins; mem_we = 0 when IF wins.
- Arbitration: DM wins by default (older instruction). IF wins if only if_req is set, or if if_req is set and streak == MAX_DM_STREAK.
- Grants:
  - if_gnt / dm_gnt = mem_req && mem_gnt && winner. Combinational, same cycle.
  - No grant while mem_gnt = 0. Winner selection may change between cycles while waiting.
- Streak counter:
  - Increments on a DM grant while if_req = 1.
  - Clears on an IF grant or whenever if_req = 0.
  - Saturates at MAX_DM_STREAK.
- Granted read (IF, or DM with we = 0): next state WAIT_RSP; owner latched.
- Granted store: completes at grant; no rvalid is generated; state stays or returns to IDLE.
- In WAIT_RSP:
  - mem_req = 0 unless mem_rvalid = 1 that cycle.
  - On mem_rvalid, drive rvalid to the owner for exactly one cycle (combinational from mem_rvalid); rdata = mem_rdata, and is 0 for the non-owner.
  - Then go to IDLE, or re-enter WAIT_RSP if a new read is granted in the same cycle.
- Latency: request-to-grant 0 cycles when memory is ready; response latency is set by memory. At most one read outstanding.
- mem_rvalid in IDLE with no read outstanding: ignored for routing; err_rsp set and held until reset.
- Reset mid-operation: outstanding read dropped, owner cleared. A late mem_rvalid after reset falls under the previous rule and sets err_rsp.
- Simultaneous if_req and dm_req with streak < MAX: DM granted; IF held (stalled).

Decomposition:
- Shared package cpu_mem_pkg holds:
  - typedef enum logic {ST_IDLE, ST_WAIT_RSP} arb_state_e
  - typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_DM} mem_owner_e
  - default ADDR_W / DATA_W localparams
- Optional sub-module mem_arb_pick: combinational winner select from if_req, dm_req and streak. Everything else stays in the top module.

Test Plan:
- Reset release, if_req = 1, addr 0x0, mem_gnt = 1, mem_rvalid 2 cycles later with 0x00500093 → if_gnt in the same cycle, if_rvalid pulse one cycle with if_rdata = 0x00500093, dm_rvalid = 0.
- if_req and dm_req (load, 0x100) asserted together → dm_gnt first; after the DM response, if_gnt; data routed to the correct owner.
- dm_req held high continuously with if_req = 1, MAX_DM_STREAK = 4, reads each completing in 1 cycle → 4 DM grants, then 1 IF grant, then the streak restarts.
- Store dm_we = 1, be = 4'b0011, wdata 0xDEADBEEF → mem_we = 1, mem_be = 0011, dm_gnt; no dm_rvalid; state stays IDLE; an IF request granted the next cycle.
- mem_gnt held 0 for 3 cycles with both requests pending → no grants, mem_req stays 1; grant on the 4th cycle.
- rst_n pulsed low while in WAIT_RSP, then mem_rvalid → no rvalid to either requester, err_rsp = 1 sticky until the next reset.
